// File: rtl/status_display_scanner.sv
// Scans a 4-digit common-anode 7-segment display showing alarm, irrigation and water status.
// Define DISPLAY_ALARM_BLINK_EN to blank the whole display on alternate blink half-periods while the alarm is latched.
module status_display_scanner #(
  parameter int REFRESH_DIV  = 50000,
  parameter int BLINK_FRAMES = 125
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] encoded_water,
  input  logic [1:0] encoded_irrigation,
  input  logic       alarm,
  output logic [6:0] segments_n,
  output logic [3:0] digit_enable_n
);

  localparam int SCAN_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(REFRESH_DIV - 1);
  localparam int FRAME_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(BLINK_FRAMES - 1);

  if (REFRESH_DIV < 2) begin : g_bad_refresh_div
    $error("status_display_scanner: REFRESH_DIV must be at least 2");
  end
  if (BLINK_FRAMES < 1) begin : g_bad_blink_frames
    $error("status_display_scanner: BLINK_FRAMES must be at least 1");
  end

  logic [4:0]        sync_meta;
  logic [4:0]        sync_out;
  logic [SCAN_W-1:0] scan_cnt;
  logic [1:0]        digit_idx;
  logic              frame_end;
  logic [1:0]        disp_water;
  logic [1:0]        disp_irrigation;
  logic              disp_alarm;
  logic              blank;

  // Packed as {alarm, irrigation, water}; all five bits cross from the controller's domain.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_meta <= '0;
      sync_out  <= '0;
    end else begin
      sync_meta <= {alarm, encoded_irrigation, encoded_water};
      sync_out  <= sync_meta;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      scan_cnt  <= '0;
      digit_idx <= '0;
    end else if (scan_cnt == SCAN_LAST) begin
      scan_cnt  <= '0;
      digit_idx <= digit_idx + 2'd1;
    end else begin
      scan_cnt  <= scan_cnt + 1'b1;
    end
  end

  assign frame_end = (scan_cnt == SCAN_LAST) && (digit_idx == 2'd3);

  // Status is only taken on the last edge of a frame so every frame shows one consistent snapshot.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      disp_water      <= '0;
      disp_irrigation <= '0;
      disp_alarm      <= 1'b0;
    end else if (frame_end) begin
      disp_water      <= sync_out[1:0];
      disp_irrigation <= sync_out[3:2];
      disp_alarm      <= sync_out[4];
    end
  end

`ifdef DISPLAY_ALARM_BLINK_EN
  logic [FRAME_W-1:0] frame_cnt;
  logic               blink_phase;

  // Held at the visible start of a half-period until an alarm is latched.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      frame_cnt   <= '0;
      blink_phase <= 1'b1;
    end else if (!disp_alarm) begin
      frame_cnt   <= '0;
      blink_phase <= 1'b1;
    end else if (frame_end) begin
      if (frame_cnt == FRAME_LAST) begin
        frame_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        frame_cnt   <= frame_cnt + 1'b1;
      end
    end
  end

  // Gating with disp_alarm makes a cleared alarm visible on the very frame it is latched.
  assign blank = disp_alarm && !blink_phase;
`else
  assign blank = 1'b0;
`endif

  always_comb begin
    segments_n     = 7'b1111111;
    digit_enable_n = 4'b1111;
    if (!blank) begin
      digit_enable_n = ~(4'b0001 << digit_idx);
      case (digit_idx)
        2'd0: segments_n = disp_alarm ? 7'b0001000 : 7'b1111111;
        2'd1: begin
          case (disp_irrigation)
            2'b00:   segments_n = 7'b0111111;
            2'b01:   segments_n = 7'b0010010;
            2'b10:   segments_n = 7'b0100001;
            default: segments_n = 7'b0000110;
          endcase
        end
        2'd2: segments_n = 7'b1111111;
        default: begin
          case (disp_water)
            2'b00:   segments_n = 7'b1000000;
            2'b01:   segments_n = 7'b1111001;
            2'b10:   segments_n = 7'b0100100;
            default: segments_n = 7'b0110000;
          endcase
        end
      endcase
    end
  end

endmodule

// File: doc/status_display_scanner.md
# status_display_scanner

Display-side consumer of the irrigation controller's status encodings: takes the 2-bit water-level code, the 2-bit irrigation code and the alarm flag, synchronises them, and drives a time-multiplexed 4-digit common-anode 7-segment display. Sits between the controller core and the board display pins. Latches new status only on frame boundaries so a digit never shows a half-updated frame. When compiled in, a slow blink signals an active alarm.

## Interface
- REFRESH_DIV, 50000: clock cycles each digit stays enabled; legal range ≥ 2.
- BLINK_FRAMES, 125: full 4-digit frames per blink half-period; legal range ≥ 1.
- clock  input  1  system clock, all state on rising edge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- encoded_water  input  2  water code: 00 empty, 01 low, 10 mid, 11 full; asynchronous to clock.
- encoded_irrigation  input  2  irrigation code: 00 off, 01 sprinkler, 10 dripper, 11 invalid; asynchronous.
- alarm  input  1  alarm request, active-high; asynchronous.
- segments_n  output  7  segment drive {g,f,e,d,c,b,a}, active-low.
- digit_enable_n  output  4  digit anodes, active-low, bit i = digit i, at most one low at a time.

## Operation
- All three inputs pass through a 2-flop synchroniser (5 bits total).
- Scan counter counts 0..REFRESH_DIV-1; on wrap, digit index advances 0→1→2→3→0.
- Frame boundary: scan counter = REFRESH_DIV-1 and digit index = 3. On that edge the display register loads the synchronised water, irrigation and alarm values.
- Digit content, decoded from the display register:
  - digit 0: 'A' (0001000) if the latched alarm is set, else blank (1111111).
  - digit 1: irrigation code. 00 '-' (0111111), 01 'S' (0010010), 10 'd' (0100001), 11 'E' (0000110).
  - digit 2: always blank.
  - digit 3: water code as numeral. 00 '0' (1000000), 01 '1' (1111001), 10 '2' (0100100), 11 '3' (0110000).
- digit_enable_n is low on the bit for the current index only. When the digit is blanked by blink, it is 1111.
- Outputs are decoded only from registered state: index, display register, blink phase. There is no direct path from input to output.
- Frame counter counts 0..BLINK_FRAMES-1 and advances at each frame boundary. On its wrap, blink phase toggles.
- Blink phase is forced to 1 (visible), and the frame counter to 0, whenever the latched alarm is 0. An alarm episode therefore always starts with a full visible half-period.

## Timing
- Reset values:
  - scan counter 0, digit index 0, frame counter 0, blink phase 1.
  - synchronisers 0; display register 0, which shows water '0', irrigation '-', no alarm.
  - outputs: digit_enable_n = 1110, segments_n = 1111111 (digit 0 blank).
- Reset asserted mid-frame: outputs return to the reset values immediately, without waiting for a clock edge.
- Digit period is exactly REFRESH_DIV cycles. Frame period is 4·REFRESH_DIV cycles.
- Input to display latency:
  - an input stable for ≥ 3 cycles before a frame-boundary edge appears from the next cycle;
  - worst case is 2 + 4·REFRESH_DIV cycles.
- Input changes shorter than one frame may be missed. This is required: the display is sampled, not captured.
- Alarm blink half-period = BLINK_FRAMES·4·REFRESH_DIV cycles. Blink transitions occur only on frame boundaries.
- Alarm deasserting in the off phase: digits are visible again from the frame boundary at which the cleared alarm is latched.

## Configuration
- DISPLAY_ALARM_BLINK_EN defined: blink logic as above (frame counter, blink phase, blanking).
- DISPLAY_ALARM_BLINK_EN undefined: no frame counter or blink phase. Display is always visible; digit 0 still shows 'A' while the latched alarm is set.

## Test plan
All scenarios use REFRESH_DIV=4, BLINK_FRAMES=2.
- Reset release with inputs at 0: digit_enable_n cycles 1110, 1101, 1011, 0111, every 4 cycles. segments_n per digit: 1111111, 0111111, 1111111, 1000000.
- encoded_water=10, encoded_irrigation=01, held before a frame boundary: next frame shows digit 3 = 0100100 and digit 1 = 0010010.
- Inputs changed mid-frame: the current frame keeps the old values on every digit; new values appear only after the digit 3 wrap edge.
- alarm=1 held (blink enabled): frames 0–1 show 'A' (0001000) on digit 0; frames 2–3 have digit_enable_n = 1111; the pattern then repeats.
- alarm deasserted during the off phase: the first frame after latching is fully visible with digit 0 blank. Same stimulus without DISPLAY_ALARM_BLINK_EN: no blank frames at any point.
- Reset asserted mid-frame while the alarm is blinking: outputs are 1110/1111111 without a clock edge; after release the sequence restarts from digit 0.
